seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Parametrised time-multiplexed seven-segment display driver that takes over the ALU calculator's display path. It scans up to 8 common-anode digits and adds a refresh prescaler, inter-digit blanking for anti-ghosting, per-digit enables, decimal points and leading-zero suppression. All inputs are snapshotted once per frame so a digit never tears mid-scan. Hex-to-segment decode is internal.

## Interface
- NUM_DIGITS, 8: digits scanned, 1..8.
- PRESCALE, 100000: clock cycles per digit slot, >= 4.
- BLANK_CYCLES, 1000: all-off cycles at the start of each slot, 1..PRESCALE-1.
- clock  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- value  input  4*NUM_DIGITS  hex nibbles; nibble i is value[4i+3:4i] and drives digit i.
- dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
- digit_en  input  NUM_DIGITS  per-digit enable, 0 = digit dark.
- lz_blank  input  1  1 = suppress leading zeros.
- anode  output  8  active-low digit select. Bits >= NUM_DIGITS are always 1.
- cathode  output  7  active-low segments; bit 0 = a … bit 6 = g.
- dp  output  1  active-low decimal point.
- frame_tick  output  1  one-cycle pulse when a new snapshot is taken.

## Operation
- **Slot counter:** `tick_cnt` counts 0..PRESCALE-1 and wraps. The digit index `idx` advances by 1 on each wrap and rolls from NUM_DIGITS-1 back to 0.
- **Snapshot:** on every edge where `tick_cnt`==0 and `idx`==0, the shadow registers capture value, dp_in, digit_en and lz_blank. frame_tick is registered 1 on that same edge. All display decisions use the shadow registers only.
- **Two-state FSM per slot:**
  - BLANK while `tick_cnt` < BLANK_CYCLES: anode = 8'hFF, cathode = 7'h7F, dp = 1.
  - DRIVE for the rest of the slot.
- **DRIVE behaviour:**
  - If digit `idx` is shown: anode[idx] = 0, cathode = pattern of nibble `idx`, dp = ~shadow_dp[idx].
  - If digit `idx` is not shown: outputs stay at their BLANK values.
- **Digit shown** = shadow_en[idx] AND NOT suppressed.
- **Suppressed** = shadow_lz AND idx != 0 AND nibble idx == 0 AND every higher nibble (below NUM_DIGITS) == 0. Digit 0 is never suppressed.
- **Segment patterns (lit segments):**
  - 0 abcdef; 1 bc; 2 abdeg; 3 abcdg
  - 4 bcfg; 5 acdfg; 6 acdefg; 7 abc
  - 8 abcdefg; 9 abcdfg; A abcefg; b cdefg
  - C adef; d bcdeg; E adefg; F aefg
- **Cathode encodings:** 0 → 7'h40, 1 → 7'h79, 4 → 7'h19, F → 7'h0E.

## Timing
- **Registered outputs:** all outputs are registered from the pre-edge counter values, so outputs lag the counter by one cycle.
- **Reset:** any edge with reset_n = 0 sets:
  - `tick_cnt` = 0, `idx` = 0, all shadows = 0;
  - anode = 8'hFF, cathode = 7'h7F, dp = 1, frame_tick = 0.
- **Mid-operation reset:** behaves identically; no partial slot continues after it.
- **First edge after reset:** the first edge with reset_n = 1 takes the snapshot and registers frame_tick = 1. Output stays blanked because BLANK_CYCLES >= 1.
- **Slot and frame periods:** each slot is PRESCALE cycles; the frame period is NUM_DIGITS*PRESCALE cycles. frame_tick fires exactly once per frame.
- **Drive window:** the drive window for digit i is registered on the edges with `tick_cnt` in [BLANK_CYCLES, PRESCALE-1]. That is PRESCALE-BLANK_CYCLES cycles of anode-low per shown digit.
- **No overlap:** no two anode bits are ever 0 simultaneously, including across slot boundaries and index wrap.
- **Input changes:** changes outside the snapshot edge have no visible effect until the next frame_tick.
- **Counter widths:** `tick_cnt` is clog2(PRESCALE) bits; `idx` is 3 bits.
- **NUM_DIGITS = 1:** `idx` stays 0, and a snapshot occurs on every slot.

## Test plan
All scenarios use NUM_DIGITS = 4, PRESCALE = 8, BLANK_CYCLES = 2.
- **Reset:** reset_n low for 3 cycles → anode 8'hFF, cathode 7'h7F, dp 1, frame_tick 0. Release → frame_tick high for exactly 1 cycle after the first high edge, then every 32 cycles.
- **Basic scan:** value = 16'h12AF, digit_en = 4'hF, lz_blank = 0.
  - Digit-0 slot: 2 blank cycles, then anode 8'hFE with cathode 7'h0E for 6 cycles.
  - Digit-3 slot: anode 8'hF7 with cathode 7'h79.
  - No cycle has two anode bits low.
- **Leading-zero suppression:** lz_blank = 1.
  - value = 16'h0040 → digit-3 and digit-2 slots keep anode 8'hFF; digit 1 shows 7'h19; digit 0 shows 7'h40.
  - value = 16'h0000 → only digit 0 lights.
- **Enables and decimal point:** digit_en = 4'b0101, dp_in = 4'b0100 → slots 1 and 3 stay anode 8'hFF. dp = 0 only during the digit-2 drive window.
- **Snapshot coherence:** change value from 16'h1111 to 16'h2222 at cycle 12 of a frame → all four digits show 1 for the rest of that frame, and 2 only from the next frame_tick.
- **Mid-frame reset:** assert reset_n = 0 for 1 cycle during the digit-2 drive window → next cycle anode 8'hFF. The scan restarts at digit 0 with a new frame_tick.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for up to 8 common-anode
// seven-segment digits. It uses a refresh prescaler, a blanking gap at the
// start of each digit slot, per-digit enables, decimal points and
// leading-zero suppression. Inputs are snapshotted once per frame so that a
// digit cannot change in the middle of a scan.
module seven_seg_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_blank,
    output logic [7:0]              anode,
    output logic [6:0]              cathode,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [TW-1:0] TICK_MAX  = TW'(PRESCALE - 1);
    localparam logic [TW-1:0] BLANK_END = TW'(BLANK_CYCLES);
    localparam logic [2:0]    IDX_MAX   = 3'(NUM_DIGITS - 1);

    // Slot phase: BLANK is the anti-ghosting gap, DRIVE lights the digit.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } phase_t;

    phase_t                  state;
    logic [TW-1:0]           tick_cnt;
    logic [2:0]              idx;
    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_en;
    logic                    shadow_lz;

    logic                    tick_wrap;
    logic [TW-1:0]           tick_next;
    logic [2:0]              idx_wrap;
    logic                    snap;
    logic [NUM_DIGITS-1:0]   zero_from;
    logic [3:0]              cur_nibble;
    logic                    cur_en;
    logic                    cur_dp;
    logic                    cur_zero;
    logic                    shown;

    // Active-low cathode pattern (bit 0 = a ... bit 6 = g) for a hex nibble.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    // Counter arithmetic: next tick value, slot wrap and frame snapshot edge.
    always_comb begin
        tick_wrap = (tick_cnt == TICK_MAX);
        tick_next = tick_wrap ? '0 : tick_cnt + 1'b1;
        idx_wrap  = (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;
        snap      = (tick_cnt == '0) && (idx == 3'd0);
    end

    // Select the current digit's shadow data and decide whether it is shown.
    always_comb begin
        // NOTE: every signal gets a default before the loops, so no path
        // leaves a value unassigned and no latch is inferred.
        zero_from  = '0;
        cur_nibble = 4'h0;
        cur_en     = 1'b0;
        cur_dp     = 1'b0;
        cur_zero   = 1'b0;
        // zero_from[i]: nibble i and every higher nibble are all zero.
        zero_from[NUM_DIGITS-1] = (shadow_value[4*NUM_DIGITS-1 -: 4] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (shadow_value[4*i +: 4] == 4'h0);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 3'(i)) begin
                cur_nibble = shadow_value[4*i +: 4];
                cur_en     = shadow_en[i];
                cur_dp     = shadow_dp[i];
                cur_zero   = zero_from[i];
            end
        end
        // Digit 0 is never suppressed, so an all-zero value still shows "0".
        shown = cur_en && !(shadow_lz && (idx != 3'd0) && cur_zero);
    end

    // Slot counter, phase FSM, frame snapshot and registered display outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            // NOTE: the shadow registers are few flops, not a memory, so they
            // are cleared with the rest of the state for a defined first frame.
            tick_cnt     <= '0;
            idx          <= 3'd0;
            state        <= ST_BLANK;
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_en    <= '0;
            shadow_lz    <= 1'b0;
            anode        <= 8'hFF;
            cathode      <= 7'h7F;
            dp           <= 1'b1;
            frame_tick   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every decision below sees the
            // pre-edge counter and shadow values.
            tick_cnt   <= tick_next;
            idx        <= tick_wrap ? idx_wrap : idx;
            state      <= (tick_next < BLANK_END) ? ST_BLANK : ST_DRIVE;
            frame_tick <= snap;
            if (snap) begin
                shadow_value <= value;
                shadow_dp    <= dp_in;
                shadow_en    <= digit_en;
                shadow_lz    <= lz_blank;
            end
            case (state)
                ST_DRIVE: begin
                    if (shown) begin
                        anode   <= ~(8'h01 << idx);
                        cathode <= seg_decode(cur_nibble);
                        dp      <= ~cur_dp;
                    end else begin
                        anode   <= 8'hFF;
                        cathode <= 7'h7F;
                        dp      <= 1'b1;
                    end
                end
                default: begin
                    anode   <= 8'hFF;
                    cathode <= 7'h7F;
                    dp      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed testbench for seven_seg_scanner with NUM_DIGITS=4, PRESCALE=8,
// BLANK_CYCLES=2 (8-cycle slots, 32-cycle frames).
module tb_seven_seg_scanner;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic        dp;
    logic        frame_tick;

    int checks = 0;
    int passed = 0;

    seven_seg_scanner #(
        .NUM_DIGITS  (4),
        .PRESCALE    (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .value     (value),
        .dp_in     (dp_in),
        .digit_en  (digit_en),
        .lz_blank  (lz_blank),
        .anode     (anode),
        .cathode   (cathode),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    always #5 clock = ~clock;

    // Hard time limit so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Runs n_edges clock edges from a frame start, checking every cycle.
    // shown/cats/dps are the hand-computed per-digit expectations; value
    // is changed to chg_val right after edge chg_at (-1 = never).
    task automatic run_frame(input logic [3:0] shown, input logic [27:0] cats,
                             input logic [3:0] dps, input int n_edges,
                             input int chg_at, input logic [15:0] chg_val);
        for (int e = 0; e < n_edges; e++) begin
            int         t;
            int         d;
            int         zeros;
            logic [7:0] exp_an;
            logic [6:0] exp_cat;
            logic       exp_dp;
            @(posedge clock);
            @(negedge clock);
            t = e % 8;
            d = e / 8;
            if (t >= 2 && shown[d]) begin
                exp_an  = 8'h01 << d;
                exp_an  = ~exp_an;
                exp_cat = cats[d*7 +: 7];
                exp_dp  = ~dps[d];
            end else begin
                exp_an  = 8'hFF;
                exp_cat = 7'h7F;
                exp_dp  = 1'b1;
            end
            zeros = 0;
            for (int b = 0; b < 8; b++) if (anode[b] == 1'b0) zeros++;
            check($sformatf("anode e%0d", e), anode, exp_an);
            check($sformatf("cathode e%0d", e), {1'b0, cathode}, {1'b0, exp_cat});
            check($sformatf("dp e%0d", e), {7'b0, dp}, {7'b0, exp_dp});
            check($sformatf("frame_tick e%0d", e), {7'b0, frame_tick}, (e == 0) ? 8'd1 : 8'd0);
            check($sformatf("anode_overlap e%0d", e), {7'b0, zeros <= 1}, 8'd1);
            if (e == chg_at) value = chg_val;
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        value    = 16'h12AF;
        dp_in    = 4'h0;
        digit_en = 4'hF;
        lz_blank = 1'b0;

        // Reset held for 3 cycles.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst anode", anode, 8'hFF);
        check("rst cathode", {1'b0, cathode}, 8'h7F);
        check("rst dp", {7'b0, dp}, 8'd1);
        check("rst frame_tick", {7'b0, frame_tick}, 8'd0);

        // Basic scan 12AF: d0=F, d1=A, d2=2, d3=1.
        reset_n = 1'b1;
        run_frame(4'hF, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'h0, 32, -1, 16'h0);

        // Leading-zero suppression 0040: digits 3 and 2 dark.
        value    = 16'h0040;
        lz_blank = 1'b1;
        run_frame(4'b0011, {7'h7F, 7'h7F, 7'h19, 7'h40}, 4'h0, 32, -1, 16'h0);

        // All zero with suppression: only digit 0 lights.
        value = 16'h0000;
        run_frame(4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'h0, 32, -1, 16'h0);

        // Enables 0101 with decimal point on digit 2.
        value    = 16'h1234;
        lz_blank = 1'b0;
        digit_en = 4'b0101;
        dp_in    = 4'b0100;
        run_frame(4'b0101, {7'h7F, 7'h24, 7'h7F, 7'h19}, 4'b0100, 32, -1, 16'h0);

        // Snapshot coherence: 1111 -> 2222 at cycle 12 shows only next frame.
        value    = 16'h1111;
        digit_en = 4'hF;
        dp_in    = 4'h0;
        run_frame(4'hF, {7'h79, 7'h79, 7'h79, 7'h79}, 4'h0, 32, 12, 16'h2222);
        run_frame(4'hF, {7'h24, 7'h24, 7'h24, 7'h24}, 4'h0, 32, -1, 16'h0);

        // Mid-frame reset inside the digit-2 drive window.
        run_frame(4'hF, {7'h24, 7'h24, 7'h24, 7'h24}, 4'h0, 21, -1, 16'h0);
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("midrst anode", anode, 8'hFF);
        check("midrst cathode", {1'b0, cathode}, 8'h7F);
        check("midrst dp", {7'b0, dp}, 8'd1);
        check("midrst frame_tick", {7'b0, frame_tick}, 8'd0);
        reset_n = 1'b1;
        value   = 16'h9C50;
        run_frame(4'hF, {7'h10, 7'h46, 7'h12, 7'h40}, 4'h0, 32, -1, 16'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
